// File: rtl/gayle_regs_if.sv
// ---------------------------------------------------------------------------
// gayle_regs_if
// 68030-side bus bundle between the CPU glue and the Gayle register block.
//   as_n     : address strobe, active low             (master -> slave)
//   rw       : 1 = read, 0 = write                     (master -> slave)
//   addr     : CPU address A[23:0]                     (master -> slave)
//   d_in     : write data D[31:24]                     (master -> slave)
//   d_out    : read data D[31:24]                      (slave -> master)
//   d_oe     : read data output enable, active high    (slave -> master)
//   dtack_n  : cycle termination, active low           (slave -> master)
//   access_n : address hits this block, active low     (slave -> master)
// ---------------------------------------------------------------------------
interface gayle_regs_if;
  logic        as_n;
  logic        rw;
  logic [23:0] addr;
  logic [7:0]  d_in;
  logic [7:0]  d_out;
  logic        d_oe;
  logic        dtack_n;
  logic        access_n;

  modport master (
    output as_n, rw, addr, d_in,
    input  d_out, d_oe, dtack_n, access_n
  );

  modport slave (
    input  as_n, rw, addr, d_in,
    output d_out, d_oe, dtack_n, access_n
  );
endinterface

// File: rtl/gayle_regs.sv
// ---------------------------------------------------------------------------
// gayle_regs
// Gayle-compatible status / IRQ / INTENA / config / serial-ID registers with
// their own DTACK, plus the drive INTRQ -> INT2 interrupt path.
//   clk_i   : bus clock
//   rst_n_i : asynchronous reset, active low
//   intrq_i : IDE drive interrupt, active high, asynchronous
//   int2_o  : interrupt request to Paula/CPU, active low
//   bus     : CPU bus bundle (gayle_regs_if.slave)
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no cycle; waiting for AS low on a selected page
// DECODE  | select/RW held; read data loaded and D_OE raised on exit
// WAIT    | ACK_DELAY down-counter running
// ACK     | DTACK low until AS is seen high
// ---------------------------------------------------------------------------
module gayle_regs #(
  parameter logic [7:0]  GAYLE_ID  = 8'hD0,
  parameter int unsigned ACK_DELAY = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        intrq_i,
  output logic        int2_o,
  gayle_regs_if.slave bus
);

  localparam int SEL_STATUS = 0;
  localparam int SEL_IRQ    = 1;
  localparam int SEL_INTENA = 2;
  localparam int SEL_CFG    = 3;
  localparam int SEL_ID     = 4;

  localparam logic [2:0] CNT_LOAD = 3'(ACK_DELAY - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DECODE, ST_WAIT, ST_ACK} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [4:0]  sel_q, sel_d;
  logic        rw_q, rw_d;
  logic [7:0]  d_out_q, d_out_d;
  logic        d_oe_q, d_oe_d;
  logic        dtack_n_q, dtack_n_d;
  logic [1:0]  sync_q;
  logic        intrq_prev_q;
  logic        irq_chg_q, irq_chg_d;
  logic        intena_q, intena_d;
  logic [3:0]  cfg_q, cfg_d;
  logic [3:0]  id_idx_q, id_idx_d;
  logic        int2_n_q, int2_n_d;

  logic [11:0] page;
  logic [4:0]  sel_live;
  logic        intrq_s;
  logic        intrq_rise;
  logic        id_bit;
  logic [7:0]  rd_data;
  logic        commit_wr;
  logic        read_done;
  logic        unused_bits;

  // Only the page and D[7:4] carry meaning for this block.
  assign unused_bits = ^{bus.addr[11:0], bus.d_in[3:0]};

  assign page = bus.addr[23:12];

  always_comb begin
    sel_live             = '0;
    sel_live[SEL_STATUS] = (page == 12'hDA8);
    sel_live[SEL_IRQ]    = (page == 12'hDA9);
    sel_live[SEL_INTENA] = (page == 12'hDAA);
    sel_live[SEL_CFG]    = (page == 12'hDAB);
    sel_live[SEL_ID]     = (page == 12'hDE1);
  end

  assign intrq_s    = sync_q[1];
  assign intrq_rise = intrq_s & ~intrq_prev_q;

  // The ID register presents one bit of GAYLE_ID per read, MSB first.
  assign id_bit = (id_idx_q < 4'd8) ? GAYLE_ID[3'd7 - id_idx_q[2:0]] : 1'b0;

  always_comb begin
    rd_data = '0;
    if (sel_q[SEL_STATUS])      rd_data = {intrq_s, 7'b0};
    else if (sel_q[SEL_IRQ])    rd_data = {irq_chg_q, 7'b0};
    else if (sel_q[SEL_INTENA]) rd_data = {intena_q, 7'b0};
    else if (sel_q[SEL_CFG])    rd_data = {cfg_q, 4'b0};
    else if (sel_q[SEL_ID])     rd_data = {id_bit, 7'b0};
  end

  // Bus cycle FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    rw_d      = rw_q;
    d_out_d   = d_out_q;
    d_oe_d    = d_oe_q;
    commit_wr = 1'b0;
    read_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!bus.as_n && (|sel_live)) begin
          state_d = ST_DECODE;
          sel_d   = sel_live;
          rw_d    = bus.rw;
        end
      end
      ST_DECODE: begin
        if (bus.as_n) begin
          state_d = ST_IDLE;
        end else begin
          if (rw_q) begin
            d_out_d = rd_data;
            d_oe_d  = 1'b1;
          end
          if (ACK_DELAY <= 1) begin
            state_d   = ST_ACK;
            commit_wr = ~rw_q;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (bus.as_n) begin
          state_d = ST_IDLE;
          d_oe_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 3'd1;
          // Terminal count: this decrement reaches zero.
          if (cnt_q == 3'd1) begin
            state_d   = ST_ACK;
            commit_wr = ~rw_q;
          end
        end
      end
      ST_ACK: begin
        if (bus.as_n) begin
          state_d   = ST_IDLE;
          d_oe_d    = 1'b0;
          read_done = rw_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dtack_n_d = (state_d != ST_ACK);

  // Register file updates.
  always_comb begin
    irq_chg_d = irq_chg_q;
    intena_d  = intena_q;
    cfg_d     = cfg_q;
    id_idx_d  = id_idx_q;
    if (commit_wr) begin
      if (sel_q[SEL_IRQ] && !bus.d_in[7]) irq_chg_d = 1'b0;
      if (sel_q[SEL_INTENA])              intena_d  = bus.d_in[7];
      if (sel_q[SEL_CFG])                 cfg_d     = bus.d_in[7:4];
      if (sel_q[SEL_ID])                  id_idx_d  = 4'd0;
    end
    if (read_done && sel_q[SEL_ID] && (id_idx_q != 4'd8)) id_idx_d = id_idx_q + 4'd1;
    // A new drive interrupt edge must never be lost to a concurrent clear.
    if (intrq_rise) irq_chg_d = 1'b1;
    int2_n_d = ~(irq_chg_q & intena_q);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      sel_q        <= '0;
      rw_q         <= 1'b1;
      d_out_q      <= '0;
      d_oe_q       <= 1'b0;
      dtack_n_q    <= 1'b1;
      sync_q       <= '0;
      intrq_prev_q <= 1'b0;
      irq_chg_q    <= 1'b0;
      intena_q     <= 1'b0;
      cfg_q        <= '0;
      id_idx_q     <= '0;
      int2_n_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      rw_q         <= rw_d;
      d_out_q      <= d_out_d;
      d_oe_q       <= d_oe_d;
      dtack_n_q    <= dtack_n_d;
      sync_q       <= {sync_q[0], intrq_i};
      intrq_prev_q <= intrq_s;
      irq_chg_q    <= irq_chg_d;
      intena_q     <= intena_d;
      cfg_q        <= cfg_d;
      id_idx_q     <= id_idx_d;
      int2_n_q     <= int2_n_d;
    end
  end

  assign bus.d_out    = d_out_q;
  assign bus.d_oe     = d_oe_q;
  assign bus.dtack_n  = dtack_n_q;
  assign bus.access_n = ~(|sel_live);
  assign int2_o       = int2_n_q;

endmodule

// File: doc/gayle_regs.md
Name: gayle_regs

Overview:
- Gayle-compatible register block that sits alongside the IDE strobe/chip-select stage on the 68030 side of the accelerator.
- Consumes the drive's INTRQ line and produces the INT2 interrupt request.
- Serves the Gayle status, IRQ, interrupt-enable and config registers and the serial Gayle ID register, so AmigaOS scsi.device detects and drives the IDE port.
- Bus cycles are terminated with its own DTACK, independent of the IDE strobe path.

Parameters:
- GAYLE_ID, 8'hD0, value shifted out MSB-first by successive ID-register reads.
- ACK_DELAY, 1, CLK cycles between the DECODE state and DTACK assertion (1..7).

Ports:
- CLK  in  1  bus clock. Registers update on the rising edge unless noted.
- RESET  in  1  asynchronous active-low reset.
- AS  in  1  CPU address strobe, active low.
- RW  in  1  1 = read, 0 = write.
- A  in  24  CPU address A[23:0].
- D_IN  in  8  CPU data D[31:24] for byte writes.
- D_OUT  out  8  read data onto D[31:24].
- D_OE  out  1  active-high data output enable.
- DTACK  out  1  active-low cycle termination.
- INTRQ  in  1  IDE drive interrupt, active high, asynchronous.
- INT2  out  1  active-low interrupt request to Paula/CPU.
- ACCESS  out  1  active-low indication that the current address hits this block.

Behaviour:
- Reset (RESET=0, asynchronous):
  - Outputs: DTACK=1, D_OE=0, D_OUT=0, INT2=1.
  - Internal state: INTENA=0, IRQ_CHG=0, CFG=4'h0, ID_IDX=0, INTRQ synchroniser=00, FSM=IDLE.
- Address decode (combinational):
  - STATUS = A[23:12]==12'hDA8.
  - IRQ = 12'hDA9.
  - INTENA = 12'hDAA.
  - CFG = 12'hDAB.
  - ID = 12'hDE1.
  - ACCESS = 0 when any select matches.
- INTRQ path:
  - Two-flop synchroniser gives INTRQ_S.
  - A rising edge of INTRQ_S (0 to 1 between consecutive clocks) sets IRQ_CHG.
  - INT2 = ~(IRQ_CHG & INTENA), registered, so it updates one clock after either term changes.
- FSM states: IDLE, DECODE, WAIT, ACK.
  - IDLE to DECODE: AS=0 sampled with any select active.
  - DECODE: latch the select and RW.
    - For reads, load D_OUT and assert D_OE on this edge.
    - Go to WAIT with the delay counter = ACK_DELAY-1, or go straight to ACK when ACK_DELAY=1.
  - WAIT: decrement the counter; go to ACK at 0.
  - ACK: drive DTACK=0.
    - A write commits on the clock of entry to ACK.
    - Stay in ACK while AS=0.
    - AS=1 sampled: DTACK=1, D_OE=0, go to IDLE. Read side effects (ID_IDX++) apply on this edge.
  - AS deasserting in DECODE or WAIT: abort to IDLE with no write commit, no ID_IDX change and DTACK never asserted.
- Register map (all registers use bit 7 of D):
  - STATUS read: D_OUT = {INTRQ_S,7'b0}. Writes are ignored.
  - IRQ read: D_OUT = {IRQ_CHG,7'b0}.
  - IRQ write: D_IN[7]=0 clears IRQ_CHG; D_IN[7]=1 leaves it unchanged.
  - Clear and INTRQ_S rising edge on the same clock: the set wins, IRQ_CHG stays 1.
  - INTENA read and write: bit7 = INTENA. Other bits read 0.
  - CFG read and write: D[7:4]=CFG. Other bits read 0.
  - ID read: D_OUT = {GAYLE_ID[7-ID_IDX],7'b0} while ID_IDX<8; D_OUT = 0 once ID_IDX=8.
    - ID_IDX increments at the end of each completed ID read and saturates at 8.
  - ID write (any data): ID_IDX=0, committed on entry to ACK.
- Back-to-back cycles: a new cycle is accepted only after IDLE is reached, which needs at least one clock with AS=1 sampled.
- Reset mid-cycle: immediate return to reset values. DTACK releases asynchronously.

Test Plan:
1. Reset release, idle bus -> DTACK=1, D_OE=0, INT2=1, ACCESS=1 with A=24'h000000.
2. Write 0xDE1000, then 5 reads of 0xDE1000 with GAYLE_ID=D0 -> bit7 sequence 1,1,0,1,0. After 8 reads the next read returns 0x00. A new write restarts the sequence at 1.
3. Write INTENA=0x80, then pulse INTRQ high -> INT2=0 within 4 clocks of the INTRQ rise.
   - Read 0xDA9000 returns 0x80.
   - Write 0x00 to 0xDA9000 -> INT2=1 one clock after ACK entry.
4. INTRQ rising edge reaches INTRQ_S on the exact clock the IRQ clear commits -> IRQ_CHG stays 1, INT2 stays 0.
5. ACK_DELAY=3, read 0xDA8000 with INTRQ=1 -> DTACK falls 3 clocks after DECODE, data 0x80.
   - AS raised in WAIT on a second cycle -> DTACK never asserts, no state change.
6. Assert RESET while in ACK of an INTENA write -> DTACK=1, INT2=1 asynchronously, INTENA reads 0x00 afterwards.
